// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time instruction memory writer.
// Takes a framed byte stream (SYNC, LEN_LO, LEN_HI, 4*N data bytes LSB-first, CHK)
// and writes little-endian words to the instruction memory. It keeps the core in
// reset until a frame passes its XOR checksum.
// Optional macro LOADER_TIMEOUT_EN adds an inter-byte timeout (err_code 11).
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 64,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned LenW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_e;

  state_e            state_q;
  logic [7:0]        len_lo_q;
  logic [LenW-1:0]   len_q;
  logic [LenW-1:0]   word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [7:0]        chk_q;

  logic              accept_c;
  logic [LenW-1:0]   len_d;
  logic [31:0]       addr_d;
  logic              tmo_hit_c;

  // Elaboration-time sanity check on the configuration.
  if (MAX_WORDS == 0 || MAX_WORDS > 65535 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("instr_mem_loader: illegal MAX_WORDS or TIMEOUT_CYCLES");
  end

  // Handshake, candidate length and the address of the word being completed.
  assign accept_c = in_valid && in_ready;
  assign len_d    = {in_data, len_lo_q};
  assign addr_d   = BASE_ADDR + 32'({word_idx_q, 2'b00});

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q;
  logic            tmo_active_c;

  assign tmo_active_c = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
  assign tmo_hit_c    = tmo_active_c && !accept_c &&
                        (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Inter-byte stall counter; cleared by each accepted byte and outside a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (!tmo_active_c || accept_c || tmo_hit_c) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Frame parser FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      chk_q      <= '0;
      in_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wd    <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      in_ready  <= 1'b1;

      unique case (state_q)
        S_IDLE, S_ERR: begin
          if (accept_c && in_data == SYNC_BYTE) begin
            state_q    <= S_LEN_LO;
            cpu_hold   <= 1'b1;
            err        <= 1'b0;
            err_code   <= 2'b00;
            chk_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept_c) begin
            len_lo_q <= in_data;
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept_c) begin
            if (len_d == '0 || len_d > LenW'(MAX_WORDS)) begin
              state_q  <= S_ERR;
              err      <= 1'b1;
              err_code <= 2'b01;
              cpu_hold <= 1'b1;
            end else begin
              len_q   <= len_d;
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept_c) begin
            chk_q      <= chk_q ^ in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wd    <= {in_data, word_q};
              imem_addr  <= addr_d;
              word_idx_q <= word_idx_q + LenW'(1);
              if (word_idx_q == len_q - LenW'(1)) begin
                state_q <= S_CHECK;
              end
            end else begin
              word_q <= {in_data, word_q[23:8]};
            end
          end
        end
        S_CHECK: begin
          if (accept_c) begin
            if (in_data == chk_q) begin
              state_q   <= S_DONE;
              in_ready  <= 1'b0;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state_q  <= S_ERR;
              err      <= 1'b1;
              err_code <= 2'b10;
              cpu_hold <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (tmo_hit_c) begin
        state_q  <= S_ERR;
        err      <= 1'b1;
        err_code <= 2'b11;
        cpu_hold <= 1'b1;
      end
    end
  end

endmodule
